// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, opcode field position,
// opcode constants used by fetch and decode, and the fetch entry type.
package cpu_pkg;

  localparam int XLEN   = 32;
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 24;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_ADD  = 8'h08;
  localparam logic [7:0] OP_MUL  = 8'h18;
  localparam logic [7:0] OP_ADDI = 8'h03;
  localparam logic [7:0] OP_SW   = 8'h19;
  localparam logic [7:0] OP_LW   = 8'h31;
  localparam logic [7:0] OP_JAL  = 8'h04;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Opcode field as seen by the control decoder.
  function automatic logic [7:0] opcode_of(input logic [XLEN-1:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: instruction-memory request/response, decode
// feedback (redirect, stall) and the IF/ID register outputs.
interface if_stage_if #(
  parameter int XLEN = cpu_pkg::XLEN
) ();

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            stall;
  logic            ifid_valid;
  logic [XLEN-1:0] ifid_instr;
  logic [XLEN-1:0] ifid_pc;
  logic [7:0]      ifid_op;

  // Fetch stage view.
  modport master (
    output imem_req_valid, imem_req_addr,
    output ifid_valid, ifid_instr, ifid_pc, ifid_op,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_target, stall
  );

  // Environment view (memory plus decode).
  modport slave (
    input  imem_req_valid, imem_req_addr,
    input  ifid_valid, ifid_instr, ifid_pc, ifid_op,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_target, stall
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; simultaneous push and pop allowed.
// Element type is a parameter so the same block serves as the prefetch
// buffer (pc + instr) and as the pc-only address-tag queue.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = fetch_entry_t,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  T                 push_data,
  input  logic             pop,
  output T                 pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T                 mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1'b1);
    end
  endfunction

  // Storage write; a flush cycle never carries a push worth keeping.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= {PTR_W{1'b0}};
      wr_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else if (flush) begin
      rd_ptr <= {PTR_W{1'b0}};
      wr_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1'b1);
        2'b01:   count <= count - CNT_W'(1'b1);
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == {CNT_W{1'b0}});

endmodule

// File: rtl/if_stage_chk.sv
// Protocol and occupancy checks for the fetch stage.
module if_stage_chk #(
  parameter int CNT_W = 2
) (
  input logic             clk,
  input logic             rst,
  input logic             resp_valid,
  input logic [CNT_W-1:0] outstanding,
  input logic [CNT_W-1:0] tag_count,
  input logic             fifo_push,
  input logic             fifo_full,
  input logic             fifo_pop,
  input logic             fifo_empty,
  input logic             tag_push,
  input logic             tag_full,
  input logic             tag_pop,
  input logic             tag_empty
);

  a_resp_has_request: assert property (@(posedge clk) disable iff (rst)
    resp_valid |-> (outstanding != {CNT_W{1'b0}}));
  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    fifo_push |-> !fifo_full);
  a_fifo_no_underflow: assert property (@(posedge clk) disable iff (rst)
    fifo_pop |-> !fifo_empty);
  a_tag_no_overflow: assert property (@(posedge clk) disable iff (rst)
    tag_push |-> !tag_full);
  a_tag_no_underflow: assert property (@(posedge clk) disable iff (rst)
    tag_pop |-> !tag_empty);
  a_tag_within_flight: assert property (@(posedge clk) disable iff (rst)
    tag_count <= outstanding);

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: sequential PC generation, credit-limited
// imem requests, prefetch FIFO, and the IF/ID pipeline register with
// stall hold and JAL redirect (stale responses are counted and dropped).
module if_stage
  import cpu_pkg::*;
#(
  parameter int              XLEN       = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input logic        clk,
  input logic        rst,
  if_stage_if.master fetch
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0]  fetch_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] tag_count;
  logic             credit_ok;
  logic             req_fire;
  logic             resp_keep;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             tag_full;
  logic             tag_empty;
  logic [XLEN-1:0]  tag_head;
  fetch_entry_t     fifo_in;
  fetch_entry_t     fifo_head;

  // Every in-flight request owns a FIFO slot, so the buffer cannot overflow.
  assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH);
  assign fetch.imem_req_valid = !rst && !fetch.redirect_valid && credit_ok;
  assign fetch.imem_req_addr  = fetch_pc;
  assign req_fire  = fetch.imem_req_valid && fetch.imem_req_ready;
  assign resp_keep = fetch.imem_resp_valid && !fetch.redirect_valid &&
                     (drop_cnt == {CNT_W{1'b0}});
  assign fifo_pop  = !fetch.redirect_valid && !fetch.stall && !fifo_empty;
  assign fifo_in.pc    = tag_head;
  assign fifo_in.instr = fetch.imem_resp_data;

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(logic [XLEN-1:0])) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (fetch.redirect_valid),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (resp_keep),
    .pop_data  (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(fetch_entry_t)) u_prefetch (
    .clk       (clk),
    .rst       (rst),
    .flush     (fetch.redirect_valid),
    .push      (resp_keep),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Fetch PC, in-flight count and pending-discard count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= {CNT_W{1'b0}};
      drop_cnt    <= {CNT_W{1'b0}};
    end else begin
      outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(fetch.imem_resp_valid);
      if (fetch.redirect_valid) begin
        fetch_pc <= fetch.redirect_target;
        // outstanding already includes responses still marked for discard,
        // so everything left in flight after this cycle is stale.
        drop_cnt <= outstanding - CNT_W'(fetch.imem_resp_valid);
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + XLEN'(3'd4);
        end
        if (fetch.imem_resp_valid && (drop_cnt != {CNT_W{1'b0}})) begin
          drop_cnt <= drop_cnt - CNT_W'(1'b1);
        end
      end
    end
  end

  // IF/ID register: redirect bubble, stall hold, load from FIFO, or bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch.ifid_valid <= 1'b0;
      fetch.ifid_instr <= {XLEN{1'b0}};
      fetch.ifid_pc    <= {XLEN{1'b0}};
      fetch.ifid_op    <= OP_NOP;
    end else if (fetch.redirect_valid) begin
      fetch.ifid_valid <= 1'b0;
      fetch.ifid_op    <= OP_NOP;
    end else if (fetch.stall) begin
      fetch.ifid_valid <= fetch.ifid_valid;
    end else if (!fifo_empty) begin
      fetch.ifid_valid <= 1'b1;
      fetch.ifid_instr <= fifo_head.instr;
      fetch.ifid_pc    <= fifo_head.pc;
      fetch.ifid_op    <= opcode_of(fifo_head.instr);
    end else begin
      fetch.ifid_valid <= 1'b0;
      fetch.ifid_op    <= OP_NOP;
    end
  end

  if_stage_chk #(.CNT_W(CNT_W)) u_chk (
    .clk         (clk),
    .rst         (rst),
    .resp_valid  (fetch.imem_resp_valid),
    .outstanding (outstanding),
    .tag_count   (tag_count),
    .fifo_push   (resp_keep),
    .fifo_full   (fifo_full),
    .fifo_pop    (fifo_pop),
    .fifo_empty  (fifo_empty),
    .tag_push    (req_fire),
    .tag_full    (tag_full),
    .tag_pop     (resp_keep),
    .tag_empty   (tag_empty)
  );

endmodule
